// File: rtl/idct_8_mac.sv
// 8-point inverse DCT: fetches 8 coefficients, then one MAC pass of 8 terms per output sample.
// Latency T+82 from start to finished; start is ignored while busy.
module idct_8_mac #(
  parameter int COEF_FRAC_BITS = 14
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               start,
  output logic [2:0]         fetch_addr,
  input  logic signed [15:0] src_data_in,
  output logic [2:0]         result_write_addr,
  output logic signed [15:0] result_out,
  output logic               result_wren,
  output logic               busy,
  output logic               finished
);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  // 8192*cos(m*pi/16), i.e. a(k)=1/2 scaled by 2^14, for m = 0..8
  function automatic int cos_base(input int m);
    case (m)
      0:       return 8192;
      1:       return 8035;
      2:       return 7568;
      3:       return 6811;
      4:       return 5793;
      5:       return 4551;
      6:       return 3135;
      7:       return 1598;
      default: return 0;
    endcase
  endfunction

  // Entry {k,n} holds C[k][n]; cosine folded by period 32 and symmetry about m=16 and m=8
  function automatic logic [1023:0] build_rom();
    logic [1023:0] rom;
    int m;
    int v;
    rom = '0;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        if (k == 0)     v = 5793;
        else if (m > 8) v = -cos_base(16 - m);
        else            v = cos_base(m);
        rom[(k * 8 + n) * 16 +: 16] = v[15:0];
      end
    end
    return rom;
  endfunction

  localparam logic [1023:0] COEF_ROM = build_rom();
  localparam logic signed [35:0] RND = 36'sd1 <<< (COEF_FRAC_BITS - 1);

  state_t             state;
  logic signed [15:0] coef [8];
  logic [3:0]         load_cnt;
  logic [2:0]         k_cnt;
  logic [2:0]         n_cnt;
  logic signed [35:0] acc;

  logic [5:0]         rom_idx;
  logic signed [15:0] rom_c;
  logic signed [31:0] prod;
  logic signed [35:0] acc_sum;
  logic signed [35:0] rounded;
  logic signed [15:0] sat_val;

  always_comb begin
    rom_idx = {k_cnt, n_cnt};
    rom_c   = COEF_ROM[{rom_idx, 4'b0000} +: 16];
    prod    = coef[k_cnt] * rom_c;
    acc_sum = acc + {{4{prod[31]}}, prod};
    rounded = (acc_sum + RND) >>> COEF_FRAC_BITS;
    if (rounded > 36'sd32767)
      sat_val = 16'sh7FFF;
    else if (rounded < -36'sd32768)
      sat_val = -16'sh8000;
    else
      sat_val = rounded[15:0];
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state             <= IDLE;
      fetch_addr        <= '0;
      result_write_addr <= '0;
      result_out        <= '0;
      result_wren       <= 1'b0;
      busy              <= 1'b0;
      finished          <= 1'b0;
      load_cnt          <= '0;
      k_cnt             <= '0;
      n_cnt             <= '0;
      acc               <= '0;
      for (int i = 0; i < 8; i++) coef[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            load_cnt   <= '0;
            fetch_addr <= '0;
            busy       <= 1'b1;
            finished   <= 1'b0;
          end
        end
        LOAD: begin
          // data for address load_cnt-1 arrives one cycle after it was driven
          if (load_cnt != 4'd0)
            coef[load_cnt[2:0] - 3'd1] <= src_data_in;
          if (load_cnt < 4'd7)
            fetch_addr <= load_cnt[2:0] + 3'd1;
          else
            fetch_addr <= '0;
          if (load_cnt == 4'd8) begin
            state <= MAC;
            k_cnt <= '0;
            n_cnt <= '0;
            acc   <= '0;
          end else begin
            load_cnt <= load_cnt + 4'd1;
          end
        end
        MAC: begin
          acc   <= acc_sum;
          k_cnt <= k_cnt + 3'd1;
          if (k_cnt == 3'd7) begin
            state             <= WRITE;
            result_out        <= sat_val;
            result_write_addr <= n_cnt;
            result_wren       <= 1'b1;
          end
        end
        WRITE: begin
          result_wren <= 1'b0;
          acc         <= '0;
          k_cnt       <= '0;
          if (n_cnt == 3'd7) begin
            state    <= DONE;
            n_cnt    <= '0;
            busy     <= 1'b0;
            finished <= 1'b1;
          end else begin
            state <= MAC;
            n_cnt <= n_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_8_mac.sv
// Self-checking bench for idct_8_mac: registered-read memory, write capture, real-valued IDCT model.
module tb_idct_8_mac;

  logic               clock = 1'b0;
  logic               nreset = 1'b0;
  logic               start = 1'b0;
  logic [2:0]         fetch_addr;
  logic signed [15:0] src_data_in;
  logic [2:0]         result_write_addr;
  logic signed [15:0] result_out;
  logic               result_wren;
  logic               busy;
  logic               finished;

  idct_8_mac #(.COEF_FRAC_BITS(14)) dut (
    .clock(clock), .nreset(nreset), .start(start), .fetch_addr(fetch_addr),
    .src_data_in(src_data_in), .result_write_addr(result_write_addr),
    .result_out(result_out), .result_wren(result_wren), .busy(busy), .finished(finished)
  );

  always #5 clock = ~clock;

  logic signed [15:0] mem [8];
  always @(posedge clock) src_data_in <= mem[fetch_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int wq_cyc[$];
  int wq_addr[$];
  logic [15:0] wq_dat[$];
  int fin_q[$];
  logic fin_prev = 1'b0;

  always @(negedge clock) begin
    if (result_wren === 1'b1) begin
      wq_cyc.push_back(cyc);
      wq_addr.push_back(int'(result_write_addr));
      wq_dat.push_back(result_out);
    end
    if (finished === 1'b1 && fin_prev !== 1'b1) fin_q.push_back(cyc);
    fin_prev = finished;
  end

  int checks = 0;
  int failures = 0;
  localparam real PI = 3.14159265358979323846;

  function automatic longint coef_model(input int k, input int n);
    real a, v;
    a = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
    v = a * $cos(real'((2 * n + 1) * k) * PI / 16.0) * 16384.0;
    if (v >= 0.0) return longint'($floor(v + 0.5));
    else          return -longint'($floor(-v + 0.5));
  endfunction

  function automatic logic [15:0] model_out(input int n);
    longint sum, r;
    sum = 0;
    for (int k = 0; k < 8; k++) sum += coef_model(k, n) * longint'(mem[k]);
    r = (sum + 64'sd8192) >>> 14;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // One full transform from a start pulse; optional start pulse at T+40 must be ignored
  task automatic run_transform(input string name, input bit pulse_busy);
    int t, base, fbase, fa_bad, exp_fa;
    logic [15:0] exp_d;
    @(negedge clock);
    start = 1'b1;
    t = cyc;
    base = wq_cyc.size();
    fbase = fin_q.size();
    fa_bad = 0;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clock);
      start = pulse_busy && (cyc == t + 40);
      exp_fa = (i <= 8) ? i - 1 : 0;
      if (fetch_addr !== 3'(exp_fa) && fa_bad == 0) begin
        fa_bad = 1;
        $display("FAIL %s fetch_addr at T+%0d: got %0d expected %0d", name, i, fetch_addr, exp_fa);
      end
      if (i == 40 && busy !== 1'b1) begin
        fa_bad = 1;
        $display("FAIL %s busy at T+40: got %b expected 1", name, busy);
      end
    end
    start = 1'b0;
    checks++;
    if (fa_bad != 0) failures++;
    checks++;
    if (wq_cyc.size() - base !== 8) begin
      failures++;
      $display("FAIL %s write count: got %0d expected 8", name, wq_cyc.size() - base);
    end
    for (int j = 0; j < 8 && base + j < wq_cyc.size(); j++) begin
      exp_d = model_out(j);
      checks++;
      if (wq_addr[base+j] !== j || wq_cyc[base+j] !== t + 18 + 9 * j || wq_dat[base+j] !== exp_d) begin
        failures++;
        $display("FAIL %s write %0d: got addr=%0d cyc=T+%0d data=%h expected addr=%0d cyc=T+%0d data=%h",
                 name, j, wq_addr[base+j], wq_cyc[base+j] - t, wq_dat[base+j], j, 18 + 9 * j, exp_d);
      end
    end
    checks++;
    if (fin_q.size() - fbase !== 1 || fin_q[fbase] !== t + 82) begin
      failures++;
      $display("FAIL %s finished rise: got count=%0d cyc=T+%0d expected one at T+82", name,
               fin_q.size() - fbase, (fin_q.size() > fbase) ? fin_q[fbase] - t : -1);
    end
    checks++;
    if (finished !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end state: got finished=%b busy=%b expected 1 0", name, finished, busy);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (fetch_addr !== 3'd0 || result_write_addr !== 3'd0 || result_out !== 16'h0000 ||
        result_wren !== 1'b0 || busy !== 1'b0 || finished !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: got fa=%0d wa=%0d out=%h wren=%b busy=%b fin=%b expected all 0",
               fetch_addr, result_write_addr, result_out, result_wren, busy, finished);
    end
    nreset = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || finished !== 1'b0 || wq_cyc.size() !== 0) begin
      failures++;
      $display("FAIL idle after reset: got busy=%b fin=%b writes=%0d expected 0 0 0",
               busy, finished, wq_cyc.size());
    end
  endtask

  task automatic test_dc();
    int b;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = 16'sh0100;
    b = wq_dat.size();
    run_transform("dc", 1'b0);
    for (int j = 0; j < 8 && b + j < wq_dat.size(); j++) begin
      checks++;
      if (wq_dat[b+j] !== 16'h005B) begin
        failures++;
        $display("FAIL dc constant %0d: got %h expected 005b", j, wq_dat[b+j]);
      end
    end
  endtask

  task automatic test_zero();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    run_transform("zero", 1'b0);
  endtask

  task automatic test_large_dc();
    int b;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = 16'sh7FFF;
    b = wq_dat.size();
    run_transform("large_dc", 1'b0);
    checks++;
    if (wq_dat.size() <= b + 7 || wq_dat[b] !== 16'h2D42 || wq_dat[b+7] !== 16'h2D42) begin
      failures++;
      $display("FAIL large_dc value: got %h expected 2d42", (wq_dat.size() > b) ? wq_dat[b] : 16'hxxxx);
    end
  endtask

  task automatic test_saturation();
    int b;
    for (int i = 0; i < 8; i++) mem[i] = 16'sh7FFF;
    b = wq_dat.size();
    run_transform("saturation", 1'b0);
    checks++;
    if (wq_dat.size() <= b || wq_dat[b] !== 16'h7FFF) begin
      failures++;
      $display("FAIL saturation out0: got %h expected 7fff", (wq_dat.size() > b) ? wq_dat[b] : 16'hxxxx);
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom_range(0, 16'hFFFF));
    run_transform("start_while_busy", 1'b1);
  endtask

  task automatic test_restart_from_done();
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom_range(0, 16'h0FFF)) - 16'sh0800;
    run_transform("restart_from_done", 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      run_transform("random", 1'b0);
    end
  endtask

  task automatic test_reset_mid_mac();
    int t, base;
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    @(negedge clock);
    start = 1'b1;
    t = cyc;
    @(negedge clock);
    start = 1'b0;
    while (cyc < t + 30) @(negedge clock);
    nreset = 1'b0;
    #1;
    base = wq_cyc.size();
    checks++;
    if (fetch_addr !== 3'd0 || result_write_addr !== 3'd0 || result_out !== 16'h0000 ||
        result_wren !== 1'b0 || busy !== 1'b0 || finished !== 1'b0) begin
      failures++;
      $display("FAIL mid_mac reset outputs: got fa=%0d wa=%0d out=%h wren=%b busy=%b fin=%b expected all 0",
               fetch_addr, result_write_addr, result_out, result_wren, busy, finished);
    end
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (wq_cyc.size() !== base || busy !== 1'b0 || finished !== 1'b0) begin
      failures++;
      $display("FAIL mid_mac abort: got writes=%0d busy=%b fin=%b expected 0 0 0",
               wq_cyc.size() - base, busy, finished);
    end
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    run_transform("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_dc();
    test_zero();
    test_large_dc();
    test_saturation();
    test_start_while_busy();
    test_restart_from_done();
    test_random();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_8_mac.md
IDCT_8_MAC -- requirements
Module: idct_8_mac

Interface
REQ-001 Parameter: COEF_FRAC_BITS, default 14, fractional bits of the internal cosine constants (signed Q1.14, 16 bits wide).
REQ-002 Port: clock, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: nreset, input, 1, reset; asynchronous, active-low.
REQ-004 Port: start, input, 1, begins one 8-point inverse transform when sampled high in IDLE or DONE.
REQ-005 Port: fetch_addr, output, 3, coefficient read address into an external synchronous-read memory with 1-cycle latency.
REQ-006 Port: src_data_in, input, 16, signed coefficient X[k]; valid the cycle after fetch_addr=k.
REQ-007 Port: result_write_addr, output, 3, output sample index n.
REQ-008 Port: result_out, output, 16, signed output sample x[n].
REQ-009 Port: result_wren, output, 1, write strobe; one cycle per output sample.
REQ-010 Port: busy, output, 1, high in LOAD, MAC and WRITE.
REQ-011 Port: finished, output, 1, high in DONE.

Function
REQ-012 The block SHALL compute x[n] = sum over k=0..7 of C[k][n]*X[k].
REQ-013 Each constant C[k][n] SHALL be round-half-away(a(k)*cos((2n+1)k*pi/16)*2^14), with a(0)=1/sqrt(8) and a(k>0)=1/2.
REQ-014 Constants SHALL be held in an internal 64-entry constant table.
REQ-015 States SHALL be IDLE, LOAD, MAC, WRITE and DONE.
REQ-016 State transitions SHALL be:
- IDLE->LOAD on start;
- LOAD->MAC after the 8th coefficient is captured;
- MAC->WRITE after 8 accumulations;
- WRITE->MAC if n<7, with n incremented;
- WRITE->DONE if n=7;
- DONE->LOAD on start.
REQ-017 Let T be the cycle in which start is sampled.
- LOAD SHALL drive fetch_addr=k on cycle T+1+k, for k=0..7.
- src_data_in SHALL be captured into internal coefficient register k at the end of cycle T+2+k.
REQ-018 The external memory SHALL be read exactly once per coefficient per transform; src_data_in SHALL be ignored outside capture cycles.
REQ-019 MAC for sample n SHALL occupy cycles T+10+9n through T+17+9n, consuming one term k=0..7 per cycle.
REQ-020 Accumulation arithmetic:
- product 16x16 signed, 32 bits;
- accumulator at least 35 bits signed;
- accumulator cleared at the start of each sample.
REQ-021 In WRITE, on cycle T+18+9n, the block SHALL assert:
- result_wren=1;
- result_write_addr=n;
- result_out=sat16((acc + 2^13) >>> 14), arithmetic shift.
REQ-022 sat16 SHALL clamp to 0x7FFF / 0x8000 on overflow.
REQ-023 result_wren SHALL be 0 in every other cycle; the last write SHALL occur on cycle T+81.
REQ-024 finished SHALL rise on cycle T+82 and hold until the next accepted start or reset.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 A start sampled in DONE SHALL clear finished in the next cycle and restart from LOAD with identical timing.
REQ-027 fetch_addr SHALL hold 0 outside LOAD; result_write_addr and result_out SHALL hold their last value outside WRITE.

Reset
REQ-028 While nreset=0, the block SHALL force:
- state=IDLE;
- fetch_addr=0, result_write_addr=0, result_out=0;
- result_wren=0, busy=0, finished=0;
- accumulator, counters and coefficient registers cleared.
REQ-029 Reset asserted mid-LOAD, mid-MAC or mid-WRITE SHALL abort the transform immediately, with no further writes.
REQ-030 After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-031 Bench memory model: memory with registered read (1-cycle latency); output captured into an 8-entry array on result_wren.
REQ-032 Scenario, DC input: X=[0x0100,0,...,0], start -> 8 writes, n=0..7 in order, all 0x005B; finished at T+82.
REQ-033 Scenario, zero input: X all 0 -> all 8 outputs 0x0000, with the same write cycles.
REQ-034 Scenario, large DC: X=[0x7FFF,0,...,0] -> all outputs 0x2D42.
REQ-035 Scenario, saturation: X all 0x7FFF -> output[0]=0x7FFF (saturated), with no wrap to negative.
REQ-036 Scenario, start while busy: pulse start at T+40 -> ignored; write cycles and results unchanged.
REQ-037 Scenario, restart from DONE: pulse start in DONE with new data -> new results, with identical timing.
REQ-038 Scenario, reset mid-MAC: assert nreset=0 at T+30 -> outputs zero at once, no result_wren; a fresh start afterwards yields correct results.
